// File: rtl/fpu_io_out_port.sv
// FPU result output stage: 4-deep result FIFO feeding a held, strobed word onto the user I/O pads.
// Optional feature macro FPU_IO_FLAGS_EN carries the IEEE exception flags on io_out[36:32].
module fpu_io_out_port #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned HOLD_W = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rstn_i,
  input  logic                     en_i,
  input  logic [HOLD_W-1:0]        hold_cycles_i,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [31:0]              res_data_i,
  input  logic [4:0]               res_flags_i,
  output logic [37:0]              io_out,
  output logic [37:0]              io_oeb,
  output logic                     strobe_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef FPU_IO_FLAGS_EN
  localparam int unsigned FW = 37;
`else
  localparam int unsigned FW = 32;
`endif

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     mem_q [DEPTH];
  logic [FW-1:0]     mem_d [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     out_q, out_d;
  logic              strobe_q, strobe_d;
  logic              overflow_q, overflow_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic              full, empty, push, pop, drive_en;
  logic [FW-1:0]     din;
  logic [HOLD_W-1:0] load_cnt;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [4:0]        flags_pins, flags_oeb;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign push     = res_valid_i && !full;
  assign load_cnt = (hold_cycles_i == '0) ? '0 : hold_cycles_i - HOLD_W'(1);

`ifdef FPU_IO_FLAGS_EN
  assign din = {res_flags_i, res_data_i};
`else
  logic unused_flags;
  assign unused_flags = ^res_flags_i;
  assign din = res_data_i;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    strobe_d = strobe_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && !empty) begin
          pop     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      out_d    = mem_q[rd_idx];
      strobe_d = ~strobe_q;
      cnt_d    = load_cnt;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_idx] = din;
    end
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d = overflow_q | (res_valid_i & full & en_i);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_q      <= '0;
      strobe_q   <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_q      <= out_d;
      strobe_q   <= strobe_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  // Reset gates the pad enables so the pads float during reset regardless of en_i.
  assign drive_en = en_i & wb_rstn_i;

`ifdef FPU_IO_FLAGS_EN
  assign flags_pins = out_q[36:32];
  assign flags_oeb  = {5{~drive_en}};
`else
  assign flags_pins = '0;
  assign flags_oeb  = '1;
`endif

  assign io_out = {strobe_q, flags_pins, out_q[31:4], 1'b0, out_q[2:0]};
  assign io_oeb = {~drive_en, flags_oeb, {28{~drive_en}}, 1'b1, {3{~drive_en}}};

  assign res_ready_o = !full;
  assign strobe_o    = strobe_q;
  assign overflow_o  = overflow_q;
  assign level_o     = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_fpu_io_out_port.sv
// Directed bench for fpu_io_out_port: scoreboard of pushed words checked on each strobe toggle.
module tb_fpu_io_out_port;

`ifdef FPU_IO_FLAGS_EN
  localparam int FW = 37;
`else
  localparam int FW = 32;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [15:0] hold;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [4:0]  flags;
  logic [37:0] io_out;
  logic [37:0] io_oeb;
  logic        strobe;
  logic        overflow;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [FW-1:0] exp_q[$];
  int tog_q[$];
  logic strobe_prev;

  fpu_io_out_port #(.DEPTH(4), .HOLD_W(16)) dut (
    .wb_clk_i      (clk),
    .wb_rstn_i     (rstn),
    .en_i          (en),
    .hold_cycles_i (hold),
    .res_valid_i   (valid),
    .res_ready_o   (ready),
    .res_data_i    (data),
    .res_flags_i   (flags),
    .io_out        (io_out),
    .io_oeb        (io_oeb),
    .strobe_o      (strobe),
    .overflow_o    (overflow),
    .level_o       (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(input logic [31:0] d);
    return d & 32'hFFFF_FFF7;
  endfunction

  function automatic logic [FW-1:0] pack(input logic [31:0] d, input logic [4:0] f);
`ifdef FPU_IO_FLAGS_EN
    return {f, d};
`else
    return d;
`endif
  endfunction

  // Call at a negedge; the offer is recorded only if the FIFO can take it at the coming edge.
  task automatic drive(input logic [31:0] d, input logic [4:0] f, output bit acc);
    valid = 1'b1;
    data  = d;
    flags = f;
    acc   = ready;
    if (ready) exp_q.push_back(pack(d, f));
  endtask

  always @(negedge clk) begin
    logic [FW-1:0] e;
    if (!rstn) begin
      strobe_prev = 1'b0;
    end else if (strobe !== strobe_prev) begin
      strobe_prev = strobe;
      tog_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("word", io_out[31:0], mask(e[31:0]));
`ifdef FPU_IO_FLAGS_EN
        chk("flags", io_out[36:32], e[36:32]);
`endif
      end
      chk("strobe_pin", io_out[37], strobe);
    end
  end

  initial begin
    bit acc;
    int nacc;
    int ntog;
    rstn = 1'b0; en = 1'b0; hold = 16'd1; valid = 1'b0; data = '0; flags = '0;
    repeat (2) @(negedge clk);
    chk("rst_io_out", io_out, 38'h0);
    chk("rst_io_oeb", io_oeb, {38{1'b1}});
    chk("rst_ready", ready, 1);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_strobe", strobe, 0);
    rstn = 1'b1; en = 1'b1; hold = 16'd1;
    @(negedge clk);

    // Latency: push at N, visible at N+2
    drive(32'h0000_0003, 5'd0, acc);
    @(negedge clk);
    valid = 1'b0;
    chk("lat_not_early", io_out[31:0], 32'h0);
    chk("lat_level", level, 1);
    @(negedge clk);
    chk("lat_word", io_out[31:0], 32'h0000_0003);
    chk("lat_oeb", io_oeb[31:0], 32'h0000_0008);
    chk("lat_strobe", strobe, 1);

    // Back-to-back, hold=4
    repeat (4) @(negedge clk);
    hold = 16'd4;
    tog_q.delete();
    drive(32'hA, 5'd0, acc); @(negedge clk);
    drive(32'hB, 5'd0, acc); @(negedge clk);
    drive(32'hC, 5'd0, acc); @(negedge clk);
    valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_toggles", tog_q.size(), 3);
    if (tog_q.size() >= 3) begin
      chk("b2b_hold_a", tog_q[1] - tog_q[0], 4);
      chk("b2b_hold_b", tog_q[2] - tog_q[1], 4);
    end
    chk("b2b_retained", io_out[31:0], mask(32'hC));
    chk("b2b_level", level, 0);

    // hold=0 behaves as hold=1
    hold = 16'd0;
    tog_q.delete();
    drive(32'h11, 5'd0, acc); @(negedge clk);
    drive(32'h22, 5'd0, acc); @(negedge clk);
    valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold0_toggles", tog_q.size(), 2);
    if (tog_q.size() >= 2) chk("hold0_interval", tog_q[1] - tog_q[0], 1);

    // Overflow: 6 offers, one popped immediately, sixth refused
    hold = 16'd100;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h100 + i, 5'd0, acc);
      nacc += int'(acc);
      @(negedge clk);
    end
    chk("ovf_level_full", level, 4);
    chk("ovf_ready_low", ready, 0);
    chk("ovf_not_yet", overflow, 0);
    drive(32'h105, 5'd0, acc);
    nacc += int'(acc);
    repeat (2) @(negedge clk);
    valid = 1'b0;
    chk("ovf_accepted", nacc, 5);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_level_hold", level, 4);

    // Asynchronous reset mid-HOLD
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_io_out", io_out, 38'h0);
    chk("arst_io_oeb", io_oeb, {38{1'b1}});
    chk("arst_level", level, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_ready", ready, 1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Enable drop mid-HOLD with two words buffered
    hold = 16'd10;
    drive(32'h1234_5678, 5'd0, acc); @(negedge clk);
    drive(32'h2222_000F, 5'd0, acc); @(negedge clk);
    drive(32'h3333_0001, 5'd0, acc); @(negedge clk);
    valid = 1'b0;
    chk("en_level_before", level, 2);
    repeat (2) @(negedge clk);
    en = 1'b0;
    ntog = tog_q.size();
    @(negedge clk);
    chk("en_off_oeb", io_oeb, {38{1'b1}});
    chk("en_off_level", level, 2);
    chk("en_off_word", io_out[31:0], mask(32'h1234_5678));
    repeat (5) @(negedge clk);
    chk("en_off_level_late", level, 2);
    chk("en_off_no_toggle", tog_q.size(), ntog);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("en_on_level", level, 1);
    chk("en_on_word", io_out[31:0], mask(32'h2222_000F));
    repeat (25) @(negedge clk);
    chk("en_drain_level", level, 0);
    chk("en_drain_word", io_out[31:0], mask(32'h3333_0001));

    // Flag pins
    hold = 16'd1;
    drive(32'h7F80_0000, 5'b00100, acc);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("flag_word", io_out[31:0], 32'h7F80_0000);
`ifdef FPU_IO_FLAGS_EN
    chk("flag_pins", io_out[36:32], 5'b00100);
    chk("flag_oeb", io_oeb[36:32], 5'b00000);
`else
    chk("flag_pins", io_out[36:32], 5'b00000);
    chk("flag_oeb", io_oeb[36:32], 5'b11111);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
